ahb_master_arbiter: RTL

Multi-master AHB arbiter placed in front of the AHB-to-APB bridge. It shares the bridge's single AHB slave port among NUM_MASTERS requesters using round-robin arbitration, locked-transfer holding and a per-owner beat limit. It muxes address-phase and data-phase signals with correct AHB pipelining, so the bridge sees exactly one well-formed master.

---
 rtl/ahb_master_arbiter_pkg.sv | 30 +++
 rtl/ahb_master_arbiter_if.sv | 38 +++
 rtl/ahb_master_arbiter_picker.sv | 30 +++
 rtl/ahb_master_arbiter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/ahb_master_arbiter_pkg.sv
// Shared transfer encodings, arbiter FSM states and index helpers
// for the multi-master AHB arbiter.
package ahb_arb_pkg;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  typedef enum logic [1:0] {
    PARK,
    OWN,
    LOCK
  } arb_state_t;

  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Masters are limited to four, so a 4-bit one-hot covers every configuration.
  function automatic logic [1:0] onehotToIdx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (oh[k]) idx = 2'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ahb_master_arbiter_if.sv
// Bus bundle between the requesting masters, the arbiter and the bridge
// slave port; the arbiter uses the slave view, the masters/bridge the master view.
interface ahb_master_arbiter_if #(
  parameter int NUM_MASTERS = 3
);

  logic [NUM_MASTERS-1:0]    Hbusreq;
  logic [NUM_MASTERS-1:0]    Hlock;
  logic [2*NUM_MASTERS-1:0]  m_Htrans;
  logic [32*NUM_MASTERS-1:0] m_Haddr;
  logic [NUM_MASTERS-1:0]    m_Hwrite;
  logic [32*NUM_MASTERS-1:0] m_Hwdata;
  logic                      Hreadyout;

  logic [NUM_MASTERS-1:0]    Hgrant;
  logic [1:0]                Hmaster;
  logic [1:0]                Hmaster_data;
  logic                      Hmastlock;
  logic                      Hready;
  logic [1:0]                s_Htrans;
  logic [31:0]               s_Haddr;
  logic                      s_Hwrite;
  logic [31:0]               s_Hwdata;
  logic                      s_Hreadyin;

  modport slave (
    input  Hbusreq, Hlock, m_Htrans, m_Haddr, m_Hwrite, m_Hwdata, Hreadyout,
    output Hgrant, Hmaster, Hmaster_data, Hmastlock, Hready,
    output s_Htrans, s_Haddr, s_Hwrite, s_Hwdata, s_Hreadyin
  );

  modport master (
    output Hbusreq, Hlock, m_Htrans, m_Haddr, m_Hwrite, m_Hwdata, Hreadyout,
    input  Hgrant, Hmaster, Hmaster_data, Hmastlock, Hready,
    input  s_Htrans, s_Haddr, s_Hwrite, s_Hwdata, s_Hreadyin
  );

endinterface

// File: rtl/ahb_master_arbiter_picker.sv
// Round-robin picker: searches requests starting just after the pointer,
// wrapping so the pointer position itself is considered last.
module rr_priority_picker
  import ahb_arb_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] i_req,
  input  logic [1:0]   i_ptr,
  output logic [N-1:0] o_grant,
  output logic         o_valid
);

  localparam int IW = idxWidth(N);

  always_comb begin
    logic [IW-1:0] pos;
    pos     = '0;
    o_grant = '0;
    o_valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      pos = IW'((int'(i_ptr) + k) % N);
      if (!o_valid && i_req[pos]) begin
        o_grant[pos] = 1'b1;
        o_valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Multi-master AHB arbiter in front of the AHB-to-APB bridge: round-robin
// grant, locked-transfer holding, beat limit and pipelined address/data muxing.
module ahb_master_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int MAX_BEATS      = 16,
  parameter int DEFAULT_MASTER = 0
) (
  input logic                 clk,
  input logic                 rst,
  ahb_master_arbiter_if.slave bus
);

  localparam int                     CNT_W     = $clog2(MAX_BEATS + 1);
  localparam logic [1:0]             DEF_IDX   = 2'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  arb_state_t             r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [1:0]             r_rrPtr;
  logic [1:0]             r_master;
  logic [1:0]             r_masterData;
  logic                   r_mastlock;
  logic [CNT_W-1:0]       r_beatCnt;

  logic [1:0]             w_trans [NUM_MASTERS];
  logic [31:0]            w_addr  [NUM_MASTERS];
  logic [31:0]            w_wdata [NUM_MASTERS];

  logic [1:0]             w_owner;
  logic                   w_ownerReq;
  logic                   w_ownerLock;
  logic [1:0]             w_ownerTrans;
  logic                   w_othersReq;
  logic                   w_sat;
  logic                   w_beatValid;
  logic                   w_rearbCond;
  logic                   w_lockEnter;
  logic                   w_lockExit;
  logic                   w_doArb;
  logic [NUM_MASTERS-1:0] w_pickGrant;
  logic                   w_pickValid;

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign w_trans[g] = bus.m_Htrans[2*g +: 2];
    assign w_addr[g]  = bus.m_Haddr[32*g +: 32];
    assign w_wdata[g] = bus.m_Hwdata[32*g +: 32];
  end

  // The granted master is the one whose request/lock/Htrans steer arbitration.
  assign w_owner      = onehotToIdx(4'(r_grant));
  assign w_ownerReq   = bus.Hbusreq[w_owner];
  assign w_ownerLock  = bus.Hlock[w_owner];
  assign w_ownerTrans = w_trans[w_owner];
  assign w_othersReq  = |(bus.Hbusreq & ~r_grant);
  assign w_sat        = (r_beatCnt == CNT_W'(MAX_BEATS));
  assign w_beatValid  = (bus.s_Htrans == NONSEQ) || (bus.s_Htrans == SEQ);

  assign w_rearbCond  = !w_ownerReq || (w_ownerTrans == IDLE) ||
                        (w_sat && w_othersReq && (w_ownerTrans != SEQ));
  assign w_lockEnter  = (r_state == OWN) && w_ownerReq && w_ownerLock &&
                        (w_ownerTrans == NONSEQ);
  assign w_lockExit   = (r_state == LOCK) && (!w_ownerLock || (w_ownerTrans == IDLE));
  assign w_doArb      = (r_state == PARK) || ((r_state == OWN) && w_rearbCond);

  // Owner is masked out so it only wins when nobody else is asking.
  rr_priority_picker #(
    .N (NUM_MASTERS)
  ) u_picker (
    .i_req   (bus.Hbusreq & ~r_grant),
    .i_ptr   (r_rrPtr),
    .o_grant (w_pickGrant),
    .o_valid (w_pickValid)
  );

  // Every register advances only on a boundary, keeping grant, address
  // phase owner and data phase owner one transfer apart.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= PARK;
      r_grant      <= DEF_GRANT;
      r_rrPtr      <= DEF_IDX;
      r_master     <= DEF_IDX;
      r_masterData <= DEF_IDX;
      r_mastlock   <= 1'b0;
      r_beatCnt    <= '0;
    end else if (bus.Hreadyout) begin
      r_master     <= w_owner;
      r_masterData <= r_master;
      r_mastlock   <= (r_state == LOCK);

      if (w_owner != r_master) begin
        r_beatCnt <= '0;
      end else if (w_beatValid && !w_sat) begin
        r_beatCnt <= r_beatCnt + CNT_W'(1);
      end

      if (w_lockEnter) begin
        r_state <= LOCK;
      end else if (w_lockExit) begin
        r_state <= OWN;
      end else if (w_doArb) begin
        if (w_pickValid) begin
          r_grant <= w_pickGrant;
          r_rrPtr <= onehotToIdx(4'(w_pickGrant));
          r_state <= OWN;
        end else if (w_ownerReq) begin
          r_rrPtr <= w_owner;
          r_state <= OWN;
        end else begin
          r_grant <= DEF_GRANT;
          r_state <= PARK;
        end
      end
    end
  end

  assign bus.Hgrant       = r_grant;
  assign bus.Hmaster      = r_master;
  assign bus.Hmaster_data = r_masterData;
  assign bus.Hmastlock    = r_mastlock;
  assign bus.Hready       = bus.Hreadyout;
  assign bus.s_Hreadyin   = bus.Hreadyout;
  assign bus.s_Htrans     = w_trans[r_master];
  assign bus.s_Haddr      = w_addr[r_master];
  assign bus.s_Hwrite     = bus.m_Hwrite[r_master];
  assign bus.s_Hwdata     = w_wdata[r_masterData];

endmodule
